// File: rtl/mem_access_unit.sv
// Load/store unit: forms the pre/post-indexed effective address and runs one byte or word
// access over a req/ack memory port, with alignment and timeout fault reporting.
module mem_access_unit #(
  parameter int unsigned WORD    = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            write_i,
  input  logic            byte_i,
  input  logic            pre_i,
  input  logic [WORD-1:0] base_i,
  input  logic [WORD-1:0] offset_i,
  input  logic [WORD-1:0] wdata_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [WORD-1:0] mem_addr_o,
  output logic [1:0]      mem_be_o,
  output logic [WORD-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [WORD-1:0] mem_rdata_i,
  output logic [WORD-1:0] rdata_o,
  output logic [WORD-1:0] base_upd_o,
  output logic            done_o,
  output logic            fault_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StFault} state_e;

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic            write_q;
  logic            byte_q;
  logic [WORD-1:0] sum_q;
  logic            req_q, we_q, done_q, fault_q, busy_q;
  logic [WORD-1:0] addr_q, wdata_q, rdata_q, base_upd_q;
  logic [1:0]      be_q;

  logic [WORD-1:0] sum, ea, wdata_new, ld_data;
  logic [1:0]      be_new;
  logic            misalign;

  always_comb begin
    sum       = base_i + offset_i;
    ea        = pre_i ? sum : base_i;
    misalign  = !byte_i && ea[0];
    be_new    = byte_i ? (ea[0] ? 2'b10 : 2'b01) : 2'b11;
    wdata_new = byte_i ? {wdata_i[7:0], wdata_i[7:0]} : wdata_i;
    // Byte loads pick the lane chosen by the latched enables and zero-extend it.
    if (!byte_q)         ld_data = mem_rdata_i;
    else if (be_q[1])    ld_data = {8'h00, mem_rdata_i[15:8]};
    else                 ld_data = {8'h00, mem_rdata_i[7:0]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      sum_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      base_upd_q <= '0;
      be_q       <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sum_q   <= sum;
            write_q <= write_i;
            byte_q  <= byte_i;
            busy_q  <= 1'b1;
            if (misalign) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              state_q <= StReq;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              we_q    <= write_i;
              addr_q  <= ea;
              be_q    <= be_new;
              wdata_q <= wdata_new;
            end
          end
        end
        StReq: begin
          if (mem_ack_i) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            base_upd_q <= sum_q;
            if (!write_q) rdata_q <= ld_data;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            // Counter started at zero, so the request was held for exactly TIMEOUT cycles.
            state_q <= StFault;
            fault_q <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone, StFault: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign base_upd_o  = base_upd_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Downstream of the memory offset selector in the multi-cycle core.
- Adds the selected offset to a base register value to form the effective address, with pre- or post-indexed addressing.
- Runs one byte or word load/store transaction on the data memory port using a req/ack handshake, and returns the load data and the updated base value for register writeback.
- Reports alignment faults and memory timeouts to the control unit.

Parameters:
- WORD, 16, data and address width in bits.
- TIMEOUT, 15, maximum number of cycles mem_req_o stays asserted without mem_ack_i before a fault is raised (1..255).

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  transaction request; accepted only when busy_o=0.
- write_i  input  1  1=store, 0=load.
- byte_i  input  1  1=byte access, 0=word access.
- pre_i  input  1  1=pre-indexed (EA=base+offset), 0=post-indexed (EA=base).
- base_i  input  WORD  base register value.
- offset_i  input  WORD  offset from the offset selector (+2, +1, -2, -1, offs or 0).
- wdata_i  input  WORD  store data.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  WORD  effective address.
- mem_be_o  output  2  byte lane enables; bit0 = low byte (even address).
- mem_wdata_o  output  WORD  memory write data.
- mem_ack_i  input  1  memory completion; read data valid in the same cycle.
- mem_rdata_i  input  WORD  memory read data.
- rdata_o  output  WORD  load result; held until the next accepted start.
- base_upd_o  output  WORD  base+offset, the writeback value; held until the next accepted start.
- done_o  output  1  one-cycle success pulse.
- fault_o  output  1  one-cycle fault pulse.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset: one clock, synchronous, active-high (rst_i). All outputs go to 0 and the FSM returns to IDLE.
- Reset mid-transaction: mem_req_o drops on the next edge, the transaction is abandoned, and no done_o or fault_o pulse is produced.
- Arithmetic: sum = base_i + offset_i, modulo 2^WORD; carry is discarded, so 0xFFFF+2 gives 0x0001. EA = pre_i ? sum : base_i.
- Latching: all inputs are captured on the accepting edge. Later input changes have no effect until the next start.
- States: IDLE, REQ, DONE, FAULT.
- IDLE: when start_i=1, latch the request.
  - Word access with EA[0]=1: go to FAULT.
  - Otherwise: go to REQ and clear the timeout counter.
- REQ: mem_req_o=1. mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are stable for the whole state.
  - mem_ack_i=1: capture load data and go to DONE.
  - Counter reaches TIMEOUT without ack: go to FAULT.
  - Otherwise: increment the counter.
  - An ack in the first REQ cycle is legal.
- DONE: done_o=1 for one cycle, base_upd_o is valid, then return to IDLE.
- FAULT: fault_o=1 for one cycle, then return to IDLE. base_upd_o and rdata_o are not updated.
- Latency: start accepted at edge N; mem_req_o high in cycle N+1; ack in cycle M gives done_o in cycle M+1. Minimum start-to-done is 2 cycles.
- Byte lanes (little-endian):
  - Word access: be=11.
  - Byte access at even EA: be=01.
  - Byte access at odd EA: be=10.
- Byte store: mem_wdata_o = {wdata_i[7:0], wdata_i[7:0]}.
- Word store: mem_wdata_o = wdata_i.
- Byte load: the selected lane is zero-extended into rdata_o. Word load: rdata_o = mem_rdata_i.
- Store: rdata_o is unchanged.
- Outside REQ: mem_req_o=0 and mem_we_o=0. mem_addr_o, mem_be_o and mem_wdata_o hold their last values.
- start_i while busy_o=1: ignored, with no queuing.
- mem_ack_i outside REQ: ignored.
- start_i in the DONE or FAULT cycle: ignored; busy_o=1 in those cycles.

Test Plan:
- Pre-indexed word load: base=0x1000, offset=0x0002, pre=1, ack after 2 cycles with rdata=0xBEEF -> addr=0x1002, be=11, rdata_o=0xBEEF, base_upd_o=0x1002, done_o pulses once.
- Post-indexed byte store: base=0x2001, offset=0xFFFF, wdata=0x12AB, ack on the first cycle -> addr=0x2001, be=10, mem_wdata_o=0xABAB, we=1, base_upd_o=0x2000, done 2 cycles after start.
- Byte load, odd address: base=0x0003, offset=0, mem_rdata=0x7F80 -> be=10, rdata_o=0x007F.
- Misaligned word store: base=0x0101, offset=0, pre=0 -> no mem_req_o, fault_o pulses the cycle after start, base_upd_o unchanged.
- Timeout and wrap: base=0xFFFF, offset=0x0001, pre=1, byte load, ack held low -> addr=0x0000; mem_req_o stays high for exactly TIMEOUT cycles, then fault_o pulses; a second start_i pulsed during REQ is ignored.
- Reset mid-REQ: assert rst_i for one cycle during REQ -> mem_req_o=0, busy_o=0 the next cycle, no done_o or fault_o; a following transaction completes normally.
